// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm siren controller slice.
//   alarm_state_e    : controller states, fixed 3-bit encoding
//   DEF_ENTRY_DELAY  : default ticks between a trip and the siren sounding
//   DEF_SIREN_TIME   : default ticks the siren sounds before auto-silence
//   DEF_CNT_W        : default timing counter width
// ---------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    ENTRY    = 3'd2,
    SIREN    = 3'd3,
    SILENCED = 3'd4
  } alarm_state_e;

  localparam int DEF_ENTRY_DELAY = 10;
  localparam int DEF_SIREN_TIME  = 30;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/alarm_siren_ctrl_if.sv
// ---------------------------------------------------------------------------
// alarm_siren_ctrl_if
// Signal bundle between the alarm gate / panel side and the siren controller.
//   Tick        : timebase strobe, one clock wide
//   Alarm_State : upstream gate output, high when armed and an entry is open
//   Enable      : arm switch
//   Siren       : siren drive
//   Pending     : entry-delay countdown in progress
//   Tripped     : latched alarm memory
//   Count       : ticks remaining in the current timed state, else 0
// Modports: master drives the inputs and observes the outputs; slave is the
// controller itself.
// ---------------------------------------------------------------------------
interface alarm_siren_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             Tick;
  logic             Alarm_State;
  logic             Enable;
  logic             Siren;
  logic             Pending;
  logic             Tripped;
  logic [CNT_W-1:0] Count;

  modport master (
    output Tick, Alarm_State, Enable,
    input  Siren, Pending, Tripped, Count
  );

  modport slave (
    input  Tick, Alarm_State, Enable,
    output Siren, Pending, Tripped, Count
  );
endinterface

// File: rtl/alarm_down_counter.sv
// ---------------------------------------------------------------------------
// alarm_down_counter
// Loadable down-counter that decrements on a strobe and saturates at zero.
//   Clock    : system clock, rising edge
//   Reset    : synchronous, active-high; clears the count
//   load     : load load_val this cycle (takes priority over dec)
//   load_val : value to load
//   dec      : decrement request; ignored when the count is already 0
//   count    : current count (registered)
//   one      : count == 1, lets the caller act on the final tick
// ---------------------------------------------------------------------------
module alarm_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             one
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign one = (count == CNT_W'(1));

endmodule

// File: rtl/alarm_siren_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_siren_ctrl
// Turns the combinational alarm gate output into timed alarm behaviour:
// entry delay, siren on-time, silenced hold until the entry closes, and a
// latched alarm-memory flag. All timing counts Tick strobes.
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : alarm_siren_ctrl_if.slave
//           in : Tick, Alarm_State, Enable
//           out: Siren, Pending, Tripped, Count (all registered)
// Parameters: ENTRY_DELAY (0 = sound immediately), SIREN_TIME (>= 1),
//             CNT_W (must hold max(ENTRY_DELAY, SIREN_TIME)).
// ---------------------------------------------------------------------------
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int ENTRY_DELAY = DEF_ENTRY_DELAY,
  parameter int SIREN_TIME  = DEF_SIREN_TIME,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic               Clock,
  input logic               Reset,
  alarm_siren_ctrl_if.slave bus
);

  localparam logic [2:0] S_DISARMED = DISARMED;
  localparam logic [2:0] S_ARMED    = ARMED;
  localparam logic [2:0] S_ENTRY    = ENTRY;
  localparam logic [2:0] S_SIREN    = SIREN;
  localparam logic [2:0] S_SILENCED = SILENCED;

  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME);

  logic [2:0]       state_q, state_d;
  logic             tripped_q, tripped_d;
  logic             siren_q, pending_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] count;
  logic             cnt_one;

  alarm_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (count),
    .one      (cnt_one)
  );

  // Next-state logic. Every timed-state entry is a counter load, so a Tick
  // arriving on that same cycle is swallowed by the load. Exiting a timed
  // state on its final tick loads the next value (or 0) instead of
  // decrementing, so the count never goes through an intermediate value.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    tripped_d    = tripped_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (!bus.Enable) begin
      // Disarm wins over all state logic; alarm memory is kept for the user.
      state_d  = S_DISARMED;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        S_DISARMED: begin
          state_d   = S_ARMED;
          tripped_d = 1'b0;
        end

        S_ARMED: begin
          if (bus.Alarm_State) begin
            cnt_load = 1'b1;
            if (ENTRY_DELAY == 0) begin
              state_d      = S_SIREN;
              cnt_load_val = SIREN_LOAD;
              tripped_d    = 1'b1;
            end else begin
              state_d      = S_ENTRY;
              cnt_load_val = ENTRY_LOAD;
            end
          end
        end

        // Alarm_State dropping does not cancel the countdown.
        S_ENTRY: begin
          if (bus.Tick) begin
            if (cnt_one) begin
              state_d      = S_SIREN;
              cnt_load     = 1'b1;
              cnt_load_val = SIREN_LOAD;
              tripped_d    = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end

        S_SIREN: begin
          if (bus.Tick) begin
            if (cnt_one) begin
              state_d  = S_SILENCED;
              cnt_load = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end

        // Hold until the entry closes so a door left open cannot retrigger.
        S_SILENCED: begin
          if (!bus.Alarm_State) begin
            state_d = S_ARMED;
          end
        end

        default: begin
          state_d  = S_DISARMED;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register rather than lagging it by a cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_DISARMED;
      siren_q   <= 1'b0;
      pending_q <= 1'b0;
      tripped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      siren_q   <= (state_d == S_SIREN);
      pending_q <= (state_d == S_ENTRY);
      tripped_q <= tripped_d;
    end
  end

  assign bus.Siren   = siren_q;
  assign bus.Pending = pending_q;
  assign bus.Tripped = tripped_q;
  assign bus.Count   = count;

endmodule
